// File: rtl/digi_ota_array_if.sv
// Bundles the comparator-array inputs, decisions and debug taps of digi_ota_array.
// Valid/ready: there is no backpressure; `ready` qualifies `out`, and every other output is valid on every cycle after reset.
interface digi_ota_array_if #(
    parameter int CH    = 4,
    parameter int CNT_W = 4
);
    logic                  en;
    logic [CH-1:0]         vip;
    logic [CH-1:0]         vin;
    logic [CH-1:0]         out;
    logic [CH-1:0]         out_en;
    logic [CH-1:0]         changed;
    logic                  ready;
    logic                  dbg_state;
    logic [CH*CNT_W-1:0]   dbg_cnt;

    modport master (
        output en, vip, vin,
        input  out, out_en, changed, ready, dbg_state, dbg_cnt
    );

    modport slave (
        input  en, vip, vin,
        output out, out_en, changed, ready, dbg_state, dbg_cnt
    );
endinterface

// File: rtl/digi_ota_array.sv
// Multi-channel digital OTA: per-channel saturating integrator with hysteresis decision.
// Optional macro DIGIOTA_SYNC_EN adds a 2-flop input synchronizer on vip/vin.
module digi_ota_array #(
    parameter int CH     = 4,
    parameter int CNT_W  = 4,
    parameter int TH_HI  = 12,
    parameter int TH_LO  = 3,
    parameter int SETTLE = 8
) (
    input logic              clk,
    input logic              rst,
    digi_ota_array_if.slave  bus
);
    localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MID     = CNT_W'(2 ** (CNT_W - 1));
    localparam logic [CNT_W-1:0] TH_HI_C     = CNT_W'(TH_HI);
    localparam logic [CNT_W-1:0] TH_LO_C     = CNT_W'(TH_LO);
    localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE - 1);

    typedef enum logic {
        ST_SETTLE = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [SW-1:0]               r_settle;
    logic [SW-1:0]               w_settle_next;
    logic [CH-1:0][CNT_W-1:0]    r_cnt;
    logic [CH-1:0][CNT_W-1:0]    w_cnt_next;
    logic [CH-1:0]               r_out;
    logic [CH-1:0]               w_out_next;
    logic [CH-1:0]               w_dec;
    logic [CH-1:0]               r_out_en;
    logic [CH-1:0]               r_changed;
    logic [CH-1:0]               w_chg_next;
    logic                        r_ready;
    logic                        w_ready_next;
    logic [CH-1:0]               w_vip;
    logic [CH-1:0]               w_vin;

`ifdef DIGIOTA_SYNC_EN
    logic [CH-1:0] r_vip_s1;
    logic [CH-1:0] r_vip_s2;
    logic [CH-1:0] r_vin_s1;
    logic [CH-1:0] r_vin_s2;

    // Synchronizer shifts regardless of en so a frozen array still sees fresh inputs on resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vip_s1 <= '0;
            r_vip_s2 <= '0;
            r_vin_s1 <= '0;
            r_vin_s2 <= '0;
        end else begin
            r_vip_s1 <= bus.vip;
            r_vip_s2 <= r_vip_s1;
            r_vin_s1 <= bus.vin;
            r_vin_s2 <= r_vin_s1;
        end
    end

    assign w_vip = r_vip_s2;
    assign w_vin = r_vin_s2;
`else
    assign w_vip = bus.vip;
    assign w_vin = bus.vin;
`endif

    always_comb begin
        w_cnt_next = r_cnt;
        w_dec      = r_out;
        for (int i = 0; i < CH; i++) begin
            if (w_vip[i] && !w_vin[i] && (r_cnt[i] != CNT_MAX)) begin
                w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
            end else if (!w_vip[i] && w_vin[i] && (r_cnt[i] != '0)) begin
                w_cnt_next[i] = r_cnt[i] - CNT_W'(1);
            end
            // Thresholds act on the post-update value so a crossing shows on out at the same edge.
            if (w_cnt_next[i] >= TH_HI_C) begin
                w_dec[i] = 1'b1;
            end else if (w_cnt_next[i] <= TH_LO_C) begin
                w_dec[i] = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_settle_next = r_settle;
        w_out_next    = r_out;
        w_chg_next    = '0;
        w_ready_next  = r_ready;
        if (bus.en) begin
            case (r_state)
                ST_SETTLE: begin
                    w_out_next = '0;
                    if (r_settle == SETTLE_LAST) begin
                        w_state_next = ST_RUN;
                        w_ready_next = 1'b1;
                    end else begin
                        w_settle_next = r_settle + SW'(1);
                    end
                end
                ST_RUN: begin
                    w_out_next = w_dec;
                    w_chg_next = w_dec ^ r_out;
                end
                default: begin
                    w_state_next = ST_SETTLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_SETTLE;
            r_settle  <= '0;
            r_cnt     <= {CH{CNT_MID}};
            r_out     <= '0;
            r_out_en  <= '0;
            r_changed <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_settle  <= w_settle_next;
            r_out     <= w_out_next;
            r_changed <= w_chg_next;
            r_ready   <= w_ready_next;
            if (bus.en) begin
                r_cnt    <= w_cnt_next;
                r_out_en <= w_vip ^ w_vin;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_en    = r_out_en;
    assign bus.changed   = r_changed;
    assign bus.ready     = r_ready;
    assign bus.dbg_state = r_state;
    assign bus.dbg_cnt   = r_cnt;
endmodule

// File: tb/tb_digi_ota_array.sv
// Scoreboard bench for digi_ota_array: directed vectors push expected outputs, a monitor pops and compares.
module tb_digi_ota_array;
  localparam int W = 29;

  logic clk;
  logic rst;
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_errors;

  digi_ota_array_if #(.CH(4), .CNT_W(4)) bus ();

  digi_ota_array #(
    .CH(4), .CNT_W(4), .TH_HI(12), .TH_LO(3), .SETTLE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.vip = '0;
    bus.vin = '0;
  end

  // driver: one call per clock, expected fields given by hand
  task automatic step(input logic r, input logic e, input logic [3:0] vp, input logic [3:0] vn,
                      input logic rdy, input logic [3:0] o, input logic [3:0] oe,
                      input logic [3:0] ch, input logic [3:0] c0, input logic [3:0] c1);
    @(negedge clk);
    rst     = r;
    bus.en  = e;
    bus.vip = vp;
    bus.vin = vn;
    exp_q.push_back({rdy, ch, oe, o, 4'd8, 4'd8, c1, c0});
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("ready",   {15'd0, bus.ready}, {15'd0, e[28]});
      chk("changed", {12'd0, bus.changed}, {12'd0, e[27:24]});
      chk("out_en",  {12'd0, bus.out_en}, {12'd0, e[23:20]});
      chk("out",     {12'd0, bus.out}, {12'd0, e[19:16]});
      chk("cnt",     bus.dbg_cnt, e[15:0]);
    end
  end

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;

    // reset for two cycles
    for (int k = 0; k < 2; k++) step(1, 0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'd8, 4'd8);

    // settle: ready rises at the 8th enabled edge
    for (int k = 1; k <= 8; k++)
      step(0, 1, 4'b0000, 4'b0000, (k == 8), 4'b0000, 4'b0000, 4'b0000, 4'd8, 4'd8);

    // ch0 climbs 9..12, crosses TH_HI on the 4th edge
    for (int k = 1; k <= 4; k++)
      step(0, 1, 4'b0001, 4'b0000, 1, (k == 4) ? 4'b0001 : 4'b0000, 4'b0001,
           (k == 4) ? 4'b0001 : 4'b0000, 4'(8 + k), 4'd8);

    // hysteresis: out holds 1 through 11..4, drops at 3
    for (int k = 1; k <= 9; k++)
      step(0, 1, 4'b0000, 4'b0001, 1, (k < 9) ? 4'b0001 : 4'b0000, 4'b0001,
           (k == 9) ? 4'b0001 : 4'b0000, 4'(12 - k), 4'd8);

    step(0, 1, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 4'b0000, 4'd3, 4'd8);

    // ch1 saturates at 15
    for (int k = 1; k <= 20; k++)
      step(0, 1, 4'b0010, 4'b0000, 1, (k >= 4) ? 4'b0010 : 4'b0000, 4'b0010,
           (k == 4) ? 4'b0010 : 4'b0000, 4'd3, (k >= 7) ? 4'd15 : 4'(8 + k));

    // freeze: en=0, inputs would move ch0/ch1 and flip out_en[0]
    for (int k = 1; k <= 5; k++)
      step(0, 0, 4'b0000, 4'b0011, 1, 4'b0010, 4'b0010, 4'b0000, 4'd3, 4'd15);

    // ch0 back up to 14, out[0] rises at 12
    for (int k = 1; k <= 11; k++)
      step(0, 1, 4'b0001, 4'b0000, 1, (k >= 9) ? 4'b0011 : 4'b0010, 4'b0001,
           (k == 9) ? 4'b0001 : 4'b0000, 4'(3 + k), 4'd15);

    // mid-operation reset
    step(1, 1, 4'b0001, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 4'd8, 4'd8);

    // settle restart with a 2-cycle en=0 gap; ch0 integrates but out stays forced low
    n = 0;
    for (int j = 1; j <= 10; j++) begin
      logic e;
      e = !(j == 4 || j == 5);
      if (e) n++;
      step(0, e, 4'b0001, 4'b0000, (j == 10), 4'b0000, 4'b0001, 4'b0000,
           (n >= 7) ? 4'd15 : 4'(8 + n), 4'd8);
    end

    // first RUN edge releases the decision
    step(0, 1, 4'b0001, 4'b0000, 1, 4'b0001, 4'b0001, 4'b0001, 4'd15, 4'd8);

    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
